// File: rtl/stk_pkg.sv
// Shared types and sizing for the stk pipeline.
// cmd_op_t  : client command opcode (PUSH/POP)
// err_t     : rejection code returned on the response channel
// ctxt_id_t : stack context identifier
package stk_pkg;

  localparam int unsigned CTXT_N  = 4;   // number of stack contexts, power of 2
  localparam int unsigned CTXT_W  = $clog2(CTXT_N);
  localparam int unsigned DEPTH_W = 10;  // per-context depth counter width

  localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;

  typedef enum logic {
    OP_PUSH = 1'b0,
    OP_POP  = 1'b1
  } cmd_op_t;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,
    ERR_NODESC = 2'd1,
    ERR_EMPTY  = 2'd2
  } err_t;

  typedef logic [CTXT_W-1:0] ctxt_id_t;

endpackage

// File: rtl/stk_pipe_ad_cnt.sv
// Per-context stack depth counters for the admission stage.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   inc_i    : increment depth of ctxt_i (ignored when saturated)
//   dec_i    : decrement depth of ctxt_i (ignored when zero)
//   ctxt_i   : context addressed by inc_i/dec_i
//   zero_o   : per-context depth == 0
//   max_o    : per-context depth == DEPTH_MAX
module stk_pipe_ad_cnt
  import stk_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              inc_i,
  input  logic              dec_i,
  input  ctxt_id_t          ctxt_i,
  output logic [CTXT_N-1:0] zero_o,
  output logic [CTXT_N-1:0] max_o
);

  logic [DEPTH_W-1:0] depth_q [CTXT_N];
  logic [DEPTH_W-1:0] depth_d [CTXT_N];

  always_comb begin
    for (int unsigned i = 0; i < CTXT_N; i++) begin
      zero_o[i] = (depth_q[i] == '0);
      max_o[i]  = (depth_q[i] == DEPTH_MAX);
    end
  end

  // The caller advances at most one command per cycle, so inc and dec never collide.
  // The guards keep the counter from wrapping even if a caller misbehaves.
  always_comb begin
    depth_d = depth_q;
    if (inc_i && !max_o[ctxt_i]) begin
      depth_d[ctxt_i] = depth_q[ctxt_i] + DEPTH_W'(1);
    end else if (dec_i && !zero_o[ctxt_i]) begin
      depth_d[ctxt_i] = depth_q[ctxt_i] - DEPTH_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < CTXT_N; i++) begin
        depth_q[i] <= '0;
      end
    end else begin
      depth_q <= depth_d;
    end
  end

endmodule

// File: rtl/stk_pipe_ad.sv
// Admission stage of the stk pipeline.
// Holds one client command, decides whether it is admissible against the per-context
// depth and the allocator state, requests a descriptor for admitted pushes, and forwards
// admitted commands to lk or returns a rejection response.
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   i_cmd_vld/i_cmd_op/i_cmd_ctxt     : client command, taken when i_cmd_vld & o_cmd_rdy
//   o_cmd_rdy                         : ad holding register can take a command
//   o_ad_alloc                        : descriptor request to al (combinational)
//   i_ad_empty_r, i_ad_busy           : al has no free descriptor / al initialising
//   i_lk_stall                        : lk cannot take a command this cycle
//   o_lk_vld_r/o_lk_op_r/o_lk_ctxt_r  : admitted command in lk stage
//   o_rsp_vld_r/o_rsp_ctxt_r/o_rsp_err_r : one-cycle rejection response
module stk_pipe_ad
  import stk_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     i_cmd_vld,
  input  cmd_op_t  i_cmd_op,
  input  ctxt_id_t i_cmd_ctxt,
  output logic     o_cmd_rdy,
  output logic     o_ad_alloc,
  input  logic     i_ad_empty_r,
  input  logic     i_ad_busy,
  input  logic     i_lk_stall,
  output logic     o_lk_vld_r,
  output cmd_op_t  o_lk_op_r,
  output ctxt_id_t o_lk_ctxt_r,
  output logic     o_rsp_vld_r,
  output ctxt_id_t o_rsp_ctxt_r,
  output err_t     o_rsp_err_r
);

  logic     ad_vld_q, ad_vld_d;
  cmd_op_t  ad_op_q, ad_op_d;
  ctxt_id_t ad_ctxt_q, ad_ctxt_d;

  logic     lk_vld_q, lk_vld_d;
  cmd_op_t  lk_op_q, lk_op_d;
  ctxt_id_t lk_ctxt_q, lk_ctxt_d;

  logic     rsp_vld_q, rsp_vld_d;
  ctxt_id_t rsp_ctxt_q, rsp_ctxt_d;
  err_t     rsp_err_q, rsp_err_d;

  logic              ad_adv, cmd_acc, push_ok, pop_ok, admit, reject;
  logic [CTXT_N-1:0] ctxt_zero, ctxt_max;

  stk_pipe_ad_cnt u_cnt (
    .clk    (clk),
    .rst    (rst),
    .inc_i  (push_ok),
    .dec_i  (pop_ok),
    .ctxt_i (ad_ctxt_q),
    .zero_o (ctxt_zero),
    .max_o  (ctxt_max)
  );

  // Advancing is gated by busy and stall so an alloc is only ever issued when lk will
  // capture the entry in the same cycle that consumes the al pointer.
  always_comb begin
    ad_adv  = ad_vld_q && !i_ad_busy && !i_lk_stall;
    cmd_acc = i_cmd_vld && o_cmd_rdy;
    push_ok = ad_adv && (ad_op_q == OP_PUSH) && !i_ad_empty_r && !ctxt_max[ad_ctxt_q];
    pop_ok  = ad_adv && (ad_op_q == OP_POP) && !ctxt_zero[ad_ctxt_q];
    admit   = push_ok || pop_ok;
    reject  = ad_adv && !admit;
  end

  assign o_cmd_rdy  = !ad_vld_q || ad_adv;
  assign o_ad_alloc = push_ok;

  always_comb begin
    ad_vld_d  = ad_vld_q;
    ad_op_d   = ad_op_q;
    ad_ctxt_d = ad_ctxt_q;
    if (cmd_acc) begin
      ad_vld_d  = 1'b1;
      ad_op_d   = i_cmd_op;
      ad_ctxt_d = i_cmd_ctxt;
    end else if (ad_adv) begin
      ad_vld_d  = 1'b0;
    end
  end

  always_comb begin
    lk_vld_d   = admit;
    lk_op_d    = lk_op_q;
    lk_ctxt_d  = lk_ctxt_q;
    rsp_vld_d  = reject;
    rsp_ctxt_d = rsp_ctxt_q;
    rsp_err_d  = rsp_err_q;
    if (admit) begin
      lk_op_d   = ad_op_q;
      lk_ctxt_d = ad_ctxt_q;
    end
    if (reject) begin
      rsp_ctxt_d = ad_ctxt_q;
      rsp_err_d  = (ad_op_q == OP_PUSH) ? ERR_NODESC : ERR_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ad_vld_q   <= 1'b0;
      ad_op_q    <= OP_PUSH;
      ad_ctxt_q  <= '0;
      lk_vld_q   <= 1'b0;
      lk_op_q    <= OP_PUSH;
      lk_ctxt_q  <= '0;
      rsp_vld_q  <= 1'b0;
      rsp_ctxt_q <= '0;
      rsp_err_q  <= ERR_NONE;
    end else begin
      ad_vld_q   <= ad_vld_d;
      ad_op_q    <= ad_op_d;
      ad_ctxt_q  <= ad_ctxt_d;
      lk_vld_q   <= lk_vld_d;
      lk_op_q    <= lk_op_d;
      lk_ctxt_q  <= lk_ctxt_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_ctxt_q <= rsp_ctxt_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign o_lk_vld_r   = lk_vld_q;
  assign o_lk_op_r    = lk_op_q;
  assign o_lk_ctxt_r  = lk_ctxt_q;
  assign o_rsp_vld_r  = rsp_vld_q;
  assign o_rsp_ctxt_r = rsp_ctxt_q;
  assign o_rsp_err_r  = rsp_err_q;

endmodule
